// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - framed serial bit transmitter with optional even parity
//
// Purpose:
//   Accepts a DATA_W-bit word with a valid/ready handshake and shifts it out
//   on a registered, idle-high line. The frame is a start bit (0), the data
//   bits LSB first, an optional even-parity bit and a stop bit (1). Each bit
//   is held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   DATA_W       - payload bits per frame (1..32)
//   CLKS_PER_BIT - clock cycles per serial bit (>= 1)
//   PARITY_EN    - 1 inserts an even-parity bit, 0 omits it
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset
//   data_in   in   payload word, latched on the accepting edge
//   valid_in  in   producer has a word on data_in
//   ready_out out  block can accept a word (IDLE and not in reset)
//   d_out     out  registered serial line, idle high
//   busy      out  high while a frame is on the line
//   done      out  one-cycle pulse in the first IDLE cycle after a frame
module serial_bit_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              d_out,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;
   logic              r_dout;
   logic              r_done;

   state_t            w_state_nx;
   logic [CNT_W-1:0]  w_cnt_nx;
   logic [IDX_W-1:0]  w_idx_nx;
   logic [DATA_W-1:0] w_shift_nx;
   logic              w_parity_nx;
   logic              w_dout_nx;
   logic              w_done_nx;
   logic              w_ready;
   logic              w_bit_end;

   assign w_ready   = (r_state == IDLE) && !reset;
   assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

   assign ready_out = w_ready;
   assign d_out     = r_dout;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = w_bit_end ? '0 : r_cnt + CNT_W'(1);
      w_idx_nx    = r_idx;
      w_shift_nx  = r_shift;
      w_parity_nx = r_parity;
      w_done_nx   = 1'b0;

      case (r_state)
         IDLE: begin
            // Bit-period counter is parked at 0 so START gets a full period.
            w_cnt_nx = '0;
            w_idx_nx = '0;
            if (valid_in && w_ready) begin
               w_state_nx  = START;
               w_shift_nx  = data_in;
               w_parity_nx = ^data_in;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nx = DATA;
               w_idx_nx   = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_idx == IDX_W'(DATA_W - 1)) begin
                  w_state_nx = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  // Next data bit moves into position 0 of the shifter.
                  w_idx_nx   = r_idx + IDX_W'(1);
                  w_shift_nx = r_shift >> 1;
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_nx = STOP;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_nx = IDLE;
               w_done_nx  = 1'b1;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase

      // The line register is loaded from the next state so the start bit
      // appears in the very first cycle after the accepting edge.
      case (w_state_nx)
         START:   w_dout_nx = 1'b0;
         DATA:    w_dout_nx = w_shift_nx[0];
         PARITY:  w_dout_nx = w_parity_nx;
         default: w_dout_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_dout   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_idx    <= w_idx_nx;
         r_shift  <= w_shift_nx;
         r_parity <= w_parity_nx;
         r_dout   <= w_dout_nx;
         r_done   <= w_done_nx;
      end
   end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - directed self-checking bench for serial_bit_tx
module tb_serial_bit_tx;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic [2:0] valid_v;
   logic [2:0] ready_v;
   logic [2:0] d_out_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;

   int n_checks;
   int n_errors;

   // Instance 0: defaults. Instance 1: no parity. Instance 2: one clock per bit.
   serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_def (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_v[0]),
      .ready_out(ready_v[0]), .d_out(d_out_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut_nopar (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_v[1]),
      .ready_out(ready_v[1]), .d_out(d_out_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut_fast (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_v[2]),
      .ready_out(ready_v[2]), .d_out(d_out_v[2]), .busy(busy_v[2]), .done(done_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just before the accepting edge; checks every cycle of the frame
   // and returns at the negedge of the done cycle. At cycle 1 data_in is
   // changed to nxt (and valid dropped unless hold) to prove the word was
   // latched. poke pulses valid with 0x00 mid-frame.
   task automatic check_frame(input int sel, input logic [7:0] w, input bit hold,
                              input logic [7:0] nxt, input bit poke);
      int         cpb;
      int         par;
      int         nb;
      int         len;
      logic [10:0] bits;
      cpb  = (sel == 2) ? 1 : 4;
      par  = (sel == 1) ? 0 : 1;
      nb   = 2 + 8 + par;
      len  = nb * cpb;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = w[i];
      if (par != 0) bits[9] = ^w;
      bits[nb - 1] = 1'b1;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         check($sformatf("i%0d_w%02h_dout_c%0d", sel, w, k), d_out_v[sel], bits[(k - 1) / cpb]);
         check($sformatf("i%0d_w%02h_busy_c%0d", sel, w, k), busy_v[sel], 1);
         check($sformatf("i%0d_w%02h_done_c%0d", sel, w, k), done_v[sel], 0);
         if (k == 1) begin
            if (!hold) valid_v[sel] = 1'b0;
            data_in = nxt;
         end
         if (poke && k == len / 2) begin
            valid_v[sel] = 1'b1;
            data_in      = 8'h00;
         end
         if (poke && k == len / 2 + 1) begin
            valid_v[sel] = 1'b0;
            data_in      = nxt;
         end
      end
      @(negedge clk);
      check($sformatf("i%0d_w%02h_done_pulse", sel, w), done_v[sel], 1);
      check($sformatf("i%0d_w%02h_done_ready", sel, w), ready_v[sel], 1);
      check($sformatf("i%0d_w%02h_done_busy", sel, w), busy_v[sel], 0);
      check($sformatf("i%0d_w%02h_done_dout", sel, w), d_out_v[sel], 1);
   endtask

   task automatic start_word(input int sel, input logic [7:0] w);
      @(negedge clk);
      check($sformatf("i%0d_ready_before_%02h", sel, w), ready_v[sel], 1);
      data_in      = w;
      valid_v[sel] = 1'b1;
   endtask

   task automatic idle_check(input int sel, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check($sformatf("i%0d_idle_busy_%0d", sel, k), busy_v[sel], 0);
         check($sformatf("i%0d_idle_done_%0d", sel, k), done_v[sel], 0);
         check($sformatf("i%0d_idle_dout_%0d", sel, k), d_out_v[sel], 1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      valid_v  = 3'b000;
      data_in  = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst_ready_%0d", s), ready_v[s], 0);
         check($sformatf("rst_dout_%0d", s), d_out_v[s], 1);
         check($sformatf("rst_busy_%0d", s), busy_v[s], 0);
         check($sformatf("rst_done_%0d", s), done_v[s], 0);
      end
      reset = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) check($sformatf("post_rst_ready_%0d", s), ready_v[s], 1);

      // Defaults, 0xA5: 0,1,0,1,0,0,1,0,1,0,1 with done 45 cycles after accept
      start_word(0, 8'hA5);
      check_frame(0, 8'hA5, 1'b0, 8'h5A, 1'b0);
      idle_check(0, 3);

      // No parity, 0xFF: 40-cycle frame, done on cycle 41
      start_word(1, 8'hFF);
      check_frame(1, 8'hFF, 1'b0, 8'h00, 1'b0);
      idle_check(1, 3);

      // Back-to-back with valid held: second start bit right after done
      start_word(0, 8'h3C);
      check_frame(0, 8'h3C, 1'b1, 8'hC3, 1'b0);
      check_frame(0, 8'hC3, 1'b0, 8'hFF, 1'b0);
      idle_check(0, 3);

      // valid pulsed with 0x00 during DATA is ignored, no extra frame
      start_word(0, 8'h96);
      check_frame(0, 8'h96, 1'b0, 8'h11, 1'b1);
      idle_check(0, 50);

      // Reset during data bit 3 of 0x5A aborts the frame
      start_word(0, 8'h5A);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) valid_v[0] = 1'b0;
      end
      check("abort_pre_busy", busy_v[0], 1);
      check("abort_pre_bit3", d_out_v[0], 1);
      reset      = 1'b1;
      valid_v[0] = 1'b1;
      data_in    = 8'h77;
      @(negedge clk);
      check("abort_dout", d_out_v[0], 1);
      check("abort_busy", busy_v[0], 0);
      check("abort_done", done_v[0], 0);
      check("abort_ready_in_reset", ready_v[0], 0);
      reset      = 1'b0;
      valid_v[0] = 1'b0;
      @(negedge clk);
      check("abort_ready_after", ready_v[0], 1);
      idle_check(0, 6);
      start_word(0, 8'h81);
      check_frame(0, 8'h81, 1'b0, 8'h7E, 1'b0);
      idle_check(0, 2);

      // One clock per bit, 0x01: 0,1,0,0,0,0,0,0,0,1,1
      start_word(2, 8'h01);
      check_frame(2, 8'h01, 1'b0, 8'hFE, 1'b0);
      idle_check(2, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
